voice_mixer: RTL and testbench
==============================

# voice_mixer

Combines the three per-voice samples from the note player into the single sample stream consumed by the codec conditioner. Each sample period is opened by `generate_next_sample`. The mixer then does four things: latches each active voice's sample as its ready pulse arrives, sums the active voices, attenuates and range-limits the sum, and presents one 18-bit sample with a one-cycle ready strobe. Its outputs drive the codec conditioner's sample input and latch input.

## Interface
- `WIDTH`, 18, sample width of every input and of the output (two's complement)
- `SHIFT`, 1, arithmetic right-shift applied to the sum before range limiting
- `clk` input 1 system clock
- `reset` input 1 synchronous, active-high; one clock; all state cleared on the rising edge where `reset`=1
- `generate_next_sample` input 1 one-cycle pulse opening a new sample period
- `voice_active` input 3 mask of voices expected this period; sampled only on `generate_next_sample`
- `sample_in1`, `sample_in2`, `sample_in3` input WIDTH voice samples; valid only when the matching ready bit is high
- `sample_ready1`, `sample_ready2`, `sample_ready3` input 1 one-cycle voice-sample strobes
- `sample_out` output WIDTH mixed sample; registered and held between updates
- `sample_ready` output 1 one-cycle pulse; `sample_out` is new in the same cycle
- `overrun` output 1 one-cycle pulse; a period was abandoned before all expected voices arrived

## Operation
- States: IDLE, COLLECT, ADD, EMIT.
- IDLE:
  - On `generate_next_sample`: latch `voice_active` into `mask`, clear `got`[2:0], go to COLLECT.
- COLLECT:
  - On `sample_readyN` with `mask[N]`=1: latch `sample_inN` into `held[N]` and set `got[N]`.
  - Ready pulses for voices with `mask[N]`=0 are ignored.
  - A duplicate ready for the same voice overwrites `held[N]`.
  - When `(got | readies_this_cycle) & mask == mask`, go to ADD.
  - If `mask`=0, COLLECT exits to ADD on its first cycle. All voices contribute 0, so the output is 0.
- ADD:
  - `sum` = sign-extended sum, to WIDTH+2 bits, of `held[N]` over the voices with `mask[N]`=1; masked-off voices contribute 0.
  - `scaled` = `sum >>> SHIFT`, arithmetic, rounding toward −∞.
  - Register `scaled`, go to EMIT.
- EMIT:
  - Range-limit `scaled` to WIDTH (see Configuration), drive `sample_out`, pulse `sample_ready`.
  - Go to IDLE, or directly to COLLECT if a start is pending.
- `generate_next_sample` while in COLLECT (period incomplete):
  - Abandon the period: no `sample_ready`, `sample_out` holds its old value, `overrun` pulses the next cycle.
  - Re-latch `mask` from `voice_active`, clear `got`, stay in COLLECT.
- `generate_next_sample` in ADD or EMIT: set `pending`. EMIT consumes `pending`, performing the IDLE start action itself.
- Simultaneous `generate_next_sample` and `sample_readyN`: the clear happens first, and the ready counts toward the new period.

## Timing
- Reset values:
  - Outputs: `sample_out`=0, `sample_ready`=0, `overrun`=0.
  - Internal: state=IDLE, `mask`=0, `got`=0, `held[*]`=0, `pending`=0.
- Latency: cycle C is the COLLECT cycle in which the last expected ready arrives. ADD is C+1. `sample_ready` and the new `sample_out` are visible at C+2.
- Minimum spacing: with `mask`=0, `generate_next_sample` at cycle G gives `sample_ready` at G+3.
- `overrun` is asserted exactly one cycle after the abandoning `generate_next_sample`.
- `reset` asserted mid-period drops all partial data. No `sample_ready` or `overrun` is issued for that period.
- Inputs are assumed synchronous to `clk`. No combinational path from any input to any output.

## Configuration
- `VOICE_MIXER_SATURATE_EN`
  - Defined: `scaled` is clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1], i.e. [−131072, 131071] for WIDTH=18.
  - Undefined: the low WIDTH bits of `scaled` are taken (wrap-around). This saves the comparators.
- ADD/EMIT timing is identical in both builds.

## Test plan
- Normal mix:
  - Stimulus: reset, `voice_active`=3'b111, `generate_next_sample`, then readies for samples 1000, 2000, 3000 on separate cycles, SHIFT=1.
  - Required: `sample_out`=3000 with a `sample_ready` pulse exactly 2 cycles after the third ready. `overrun` stays 0.
- Partial mask:
  - Stimulus: mask 3'b101, samples −1000 and −1001. Also a ready on voice 2 with 5000.
  - Required: voice 2 is ignored. (−2001)>>>1 gives `sample_out`=−1001.
- Saturation:
  - Stimulus: all voices 131071, SHIFT=1, giving `scaled`=196606.
  - Required with `VOICE_MIXER_SATURATE_EN`: `sample_out`=131071.
  - Required without it: `sample_out`=−65538 (18'h2FFFE).
- Overrun:
  - Stimulus: mask 3'b111, only voices 1 and 2 ready, then a second `generate_next_sample`.
  - Required: `overrun` pulses 1 cycle later and `sample_out` is unchanged. Then three readies of 10 each yield `sample_out`=15.
- Edge cases:
  - Mask 0: `sample_out`=0 at G+3.
  - `sample_ready1` coincident with `generate_next_sample`: counted in the new period.
  - `reset` during COLLECT: no output pulses, and all outputs return to 0.

Source files
------------

// File: rtl/voice_mixer.sv
// Three-voice sample mixer: collects per-voice samples each period, sums, shifts, range-limits, strobes.
// Optional clamp build: define VOICE_MIXER_SATURATE_EN (default build wraps to WIDTH bits).
module voice_mixer #(
    parameter int WIDTH = 18,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             generate_next_sample,
    input  logic [2:0]       voice_active,
    input  logic [WIDTH-1:0] sample_in1,
    input  logic [WIDTH-1:0] sample_in2,
    input  logic [WIDTH-1:0] sample_in3,
    input  logic             sample_ready1,
    input  logic             sample_ready2,
    input  logic             sample_ready3,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_ready,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, COLLECT, ADD, EMIT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       mask_q, mask_d;
    logic [2:0]       got_q, got_d;
    logic [WIDTH-1:0] held_q [3];
    logic [WIDTH-1:0] held_d [3];
    logic             pending_q, pending_d;
    logic [2:0]       pend_mask_q, pend_mask_d;
    logic [WIDTH-1:0] sample_out_q, sample_out_d;
    logic             sample_ready_q, sample_ready_d;
    logic             overrun_q, overrun_d;

    logic [2:0]       rdy;
    logic [WIDTH-1:0] in_w [3];
    logic             start;
    logic [2:0]       start_mask;
    logic signed [WIDTH+1:0] sum;
    logic [WIDTH-1:0] limited;

    assign rdy     = {sample_ready3, sample_ready2, sample_ready1};
    assign in_w[0] = sample_in1;
    assign in_w[1] = sample_in2;
    assign in_w[2] = sample_in3;

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (mask_q[i]) begin
                sum = sum + {{2{held_q[i][WIDTH-1]}}, held_q[i]};
            end
        end
    end

`ifdef VOICE_MIXER_SATURATE_EN
    logic signed [WIDTH+1:0] scaled;
    localparam logic signed [WIDTH+1:0] MAX_V = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] MIN_V = {3'b111, {(WIDTH-1){1'b0}}};

    always_comb begin
        scaled = sum >>> SHIFT;
        if (scaled > MAX_V) begin
            limited = MAX_V[WIDTH-1:0];
        end else if (scaled < MIN_V) begin
            limited = MIN_V[WIDTH-1:0];
        end else begin
            limited = scaled[WIDTH-1:0];
        end
    end
`else
    always_comb begin
        limited = WIDTH'(sum >>> SHIFT);
    end
`endif

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        got_d          = got_q;
        held_d         = held_q;
        pending_d      = pending_q;
        pend_mask_d    = pend_mask_q;
        sample_out_d   = sample_out_q;
        sample_ready_d = 1'b0;
        overrun_d      = 1'b0;
        start          = 1'b0;
        start_mask     = voice_active;

        case (state_q)
            IDLE: begin
                if (generate_next_sample) start = 1'b1;
            end
            COLLECT: begin
                if (generate_next_sample) begin
                    if ((got_q & mask_q) == mask_q) begin
                        state_d     = ADD;
                        pending_d   = 1'b1;
                        pend_mask_d = voice_active;
                    end else begin
                        start     = 1'b1;
                        overrun_d = 1'b1;
                    end
                end else begin
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (rdy[i] && mask_q[i]) begin
                            held_d[i] = in_w[i];
                            got_d[i]  = 1'b1;
                        end
                    end
                    if (((got_q | rdy) & mask_q) == mask_q) state_d = ADD;
                end
            end
            // The limited mix is registered straight into sample_out here, so it
            // becomes visible (with its strobe) during the EMIT cycle.
            ADD: begin
                sample_out_d   = limited;
                sample_ready_d = 1'b1;
                state_d        = EMIT;
                if (generate_next_sample) begin
                    pending_d   = 1'b1;
                    pend_mask_d = voice_active;
                end
            end
            EMIT: begin
                pending_d = 1'b0;
                if (generate_next_sample) begin
                    start = 1'b1;
                end else if (pending_q) begin
                    start      = 1'b1;
                    start_mask = pend_mask_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Opening a period clears first, then lets same-cycle readies count.
        if (start) begin
            state_d = COLLECT;
            mask_d  = start_mask;
            got_d   = rdy & start_mask;
            for (int unsigned i = 0; i < 3; i++) begin
                if (rdy[i] && start_mask[i]) held_d[i] = in_w[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            mask_q         <= '0;
            got_q          <= '0;
            for (int unsigned i = 0; i < 3; i++) held_q[i] <= '0;
            pending_q      <= 1'b0;
            pend_mask_q    <= '0;
            sample_out_q   <= '0;
            sample_ready_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            got_q          <= got_d;
            held_q         <= held_d;
            pending_q      <= pending_d;
            pend_mask_q    <= pend_mask_d;
            sample_out_q   <= sample_out_d;
            sample_ready_q <= sample_ready_d;
            overrun_q      <= overrun_d;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_ready = sample_ready_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed + randomized self-checking bench for voice_mixer against an arithmetic mix model.
module tb_voice_mixer;
    localparam int W  = 18;
    localparam int SH = 1;

    logic         clk = 1'b0;
    logic         reset, gen;
    logic [2:0]   va;
    logic [W-1:0] s1, s2, s3;
    logic         r1, r2, r3;
    logic [W-1:0] so;
    logic         sr, ov;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    voice_mixer #(.WIDTH(W), .SHIFT(SH)) dut (
        .clk(clk), .reset(reset), .generate_next_sample(gen), .voice_active(va),
        .sample_in1(s1), .sample_in2(s2), .sample_in3(s3),
        .sample_ready1(r1), .sample_ready2(r2), .sample_ready3(r3),
        .sample_out(so), .sample_ready(sr), .overrun(ov)
    );

    function automatic int model(input bit [2:0] m, input int a, input int b, input int c);
        int sum, scaled, r;
        sum = (m[0] ? a : 0) + (m[1] ? b : 0) + (m[2] ? c : 0);
        scaled = sum >>> SH;
`ifdef VOICE_MIXER_SATURATE_EN
        if (scaled > (1 << (W-1)) - 1) r = (1 << (W-1)) - 1;
        else if (scaled < -(1 << (W-1))) r = -(1 << (W-1));
        else r = scaled;
`else
        r = scaled & ((1 << W) - 1);
        if (r >= (1 << (W-1))) r = r - (1 << W);
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        gen = 1'b0; r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
    endtask

    task automatic set_ready(input int idx, input int val);
        case (idx)
            0: begin r1 = 1'b1; s1 = val[W-1:0]; end
            1: begin r2 = 1'b1; s2 = val[W-1:0]; end
            default: begin r3 = 1'b1; s3 = val[W-1:0]; end
        endcase
    endtask

    task automatic chk_val(input string tag, input int exp);
        logic signed [31:0] obs;
        obs = $signed(so);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // From the cycle after the last expected ready (ADD): no strobe, then strobe + value.
    task automatic expect_emit(input string tag, input int exp);
        chk_bit({tag, "_add_nordy"}, sr, 1'b0);
        step();
        chk_bit({tag, "_rdy"}, sr, 1'b1);
        chk_val({tag, "_out"}, exp);
        chk_bit({tag, "_noovr"}, ov, 1'b0);
    endtask

    task automatic rand_period();
        int      v[3];
        int      q[$];
        int      j, t, exp;
        bit [2:0] m;
        m = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++) v[i] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
        for (int i = 0; i < 3; i++) if (m[i]) q.push_back(i);
        for (int i = 0; i < q.size(); i++) begin
            j = $urandom_range(0, q.size() - 1);
            t = q[i]; q[i] = q[j]; q[j] = t;
        end
        exp = model(m, v[0], v[1], v[2]);
        va = m; gen = 1'b1;
        step();
        clear_in();
        if (q.size() == 0) begin
            step();
        end else begin
            foreach (q[k]) begin
                repeat ($urandom_range(0, 2)) begin
                    for (int i = 0; i < 3; i++)
                        if (!m[i] && $urandom_range(0, 1) == 1) set_ready(i, int'($urandom));
                    step();
                    clear_in();
                    chk_bit("rnd_gap_rdy", sr, 1'b0);
                end
                set_ready(q[k], v[q[k]]);
                step();
                clear_in();
            end
        end
        expect_emit("rnd", exp);
        step();
        chk_bit("rnd_strobe_one_cycle", sr, 1'b0);
    endtask

    initial begin
        int sat_exp, prev;
        reset = 1'b1; va = '0; s1 = '0; s2 = '0; s3 = '0;
        clear_in();
        step(); step();
        reset = 1'b0;
        chk_val("reset_out", 0);
        chk_bit("reset_rdy", sr, 1'b0);
        chk_bit("reset_ovr", ov, 1'b0);

        // Normal mix
        va = 3'b111; gen = 1'b1; step(); clear_in();
        set_ready(0, 1000); step(); clear_in();
        set_ready(1, 2000); step(); clear_in();
        set_ready(2, 3000); step(); clear_in();
        expect_emit("normal", 3000);
        step();

        // Partial mask, voice 2 ignored
        va = 3'b101; gen = 1'b1; step(); clear_in();
        set_ready(0, -1000); set_ready(1, 5000); step(); clear_in();
        set_ready(2, -1001); step(); clear_in();
        expect_emit("partial", -1001);
        step();

        // Duplicate ready overwrites the held sample
        va = 3'b011; gen = 1'b1; step(); clear_in();
        set_ready(0, 40); step(); clear_in();
        set_ready(0, 80); step(); clear_in();
        set_ready(1, 20); step(); clear_in();
        expect_emit("dup", 50);
        step();

        // Saturation / wrap
`ifdef VOICE_MIXER_SATURATE_EN
        sat_exp = 131071;
`else
        sat_exp = -65538;
`endif
        va = 3'b111; gen = 1'b1; step(); clear_in();
        set_ready(0, 131071); step(); clear_in();
        set_ready(1, 131071); step(); clear_in();
        set_ready(2, 131071); step(); clear_in();
        expect_emit("sat", sat_exp);
        step();

        // Overrun
        va = 3'b111; gen = 1'b1; step(); clear_in();
        set_ready(0, 500); step(); clear_in();
        set_ready(1, 600); step(); clear_in();
        va = 3'b111; gen = 1'b1; step(); clear_in();
        chk_bit("ovr_pulse", ov, 1'b1);
        chk_bit("ovr_nordy", sr, 1'b0);
        chk_val("ovr_hold", sat_exp);
        set_ready(0, 10); step(); clear_in();
        chk_bit("ovr_one_cycle", ov, 1'b0);
        set_ready(1, 10); step(); clear_in();
        set_ready(2, 10); step(); clear_in();
        expect_emit("ovr_after", 15);
        step();

        // Ready coincident with the opening strobe
        va = 3'b001; gen = 1'b1; set_ready(0, 300); step(); clear_in();
        step();
        expect_emit("coinc", 150);
        step();

        // Mask 0: strobe at G+3
        va = 3'b000; gen = 1'b1; step(); clear_in();
        chk_bit("mask0_g1", sr, 1'b0);
        step();
        chk_bit("mask0_g2", sr, 1'b0);
        step();
        chk_bit("mask0_g3_rdy", sr, 1'b1);
        chk_val("mask0_out", 0);
        step();

        // Start arriving during ADD is held pending and opened by EMIT
        va = 3'b011; gen = 1'b1; step(); clear_in();
        set_ready(0, 7); set_ready(1, 8); step(); clear_in();
        va = 3'b000; gen = 1'b1;
        chk_bit("pend_add_nordy", sr, 1'b0);
        step(); clear_in();
        chk_bit("pend_first_rdy", sr, 1'b1);
        chk_val("pend_first_out", 7);
        step(); step();
        chk_bit("pend_add2_nordy", sr, 1'b0);
        step();
        chk_bit("pend_second_rdy", sr, 1'b1);
        chk_val("pend_second_out", 0);
        step();

        for (int n = 0; n < 25; n++) rand_period();

        // Reset mid-COLLECT
        va = 3'b111; gen = 1'b1; step(); clear_in();
        set_ready(0, 1234); step(); clear_in();
        reset = 1'b1; step(); reset = 1'b0;
        chk_val("rst_mid_out", 0);
        chk_bit("rst_mid_rdy", sr, 1'b0);
        chk_bit("rst_mid_ovr", ov, 1'b0);
        prev = 0;
        set_ready(1, 222); step(); clear_in();
        set_ready(2, 333); step(); clear_in();
        for (int i = 0; i < 4; i++) begin
            chk_bit("rst_mid_quiet_rdy", sr, 1'b0);
            chk_bit("rst_mid_quiet_ovr", ov, 1'b0);
            step();
        end
        chk_val("rst_mid_hold", prev);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
